// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : unified_mem_arbiter
// Brief   : Arbitrates one single-port, variable-latency memory between the
//           instruction-fetch port (read-only) and the data port (load/store).
//           Data accesses have priority. A starvation counter forces a fetch
//           grant after STARVE_LIMIT consecutive data grants. A branch flush
//           suppresses the response of an outstanding fetch.
// Revision: 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DAT_WIDTH    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic [DAT_WIDTH-1:0]  if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DAT_WIDTH-1:0]  d_wdata,
  output logic [DAT_WIDTH-1:0]  d_rdata,
  output logic                  d_valid,
  output logic                  d_stall,
  // memory port
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DAT_WIDTH-1:0]  mem_wdata,
  input  logic [DAT_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  // Saturation value of the starvation counter (legal limits fit in 4 bits)
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                state_q,     state_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  drop_q,      drop_d;
  logic                  mem_req_q,   mem_req_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DAT_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DAT_WIDTH-1:0]  if_rdata_q,  if_rdata_d;
  logic [DAT_WIDTH-1:0]  d_rdata_q,   d_rdata_d;

  // A fetch raised together with a flush is stale and is not eligible
  logic fetch_ok;
  logic fetch_forced;
  assign fetch_ok     = if_req & ~if_flush;
  assign fetch_forced = fetch_ok & (starve_cnt_q == STARVE_MAX);

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Grant selection, memory sequencing and response capture
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Count data grants that overtake a waiting fetch
          if (if_req && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (fetch_ok) begin
          state_d      = BUSY_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          starve_cnt_d = 4'd0;
        end
      end

      BUSY_I: begin
        // The access cannot be aborted; only its response is discarded
        if (if_flush) begin
          drop_d = 1'b1;
        end
        if (mem_ready) begin
          if_rdata_d = mem_rdata;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = RESP_I;
        end
      end

      BUSY_D: begin
        if (mem_ready) begin
          d_rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP_D;
        end
      end

      RESP_I: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end

      RESP_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Response pulses last exactly the one RESP cycle
  assign if_valid  = (state_q == RESP_I) & ~drop_q;
  assign d_valid   = (state_q == RESP_D);

  // A flushed fetch keeps stalling until its replacement completes
  assign if_stall  = if_req & ~if_valid;
  assign d_stall   = d_req  & ~d_valid;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_unified_mem_arbiter
// Brief   : Directed self-checking bench for unified_mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_stall, d_valid, d_stall, mem_req, mem_we;

  int errors = 0;
  int checks = 0;

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] st;
  int          dcnt;
  int          maxst;
  bit          seen_fetch;
  bit          done;

  initial begin
    rst = 1'b1; if_req = 0; if_flush = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    #12;
    st = 32'(dut.state_q);
    chk("rst_state", st, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ---- fetch only ----
    if_req = 1; if_addr = 32'h100;
    #1 chk("f_stall_pre", 32'(if_stall), 32'd1);
    tick();
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("f_wait_valid", 32'(if_valid), 32'd0);
    chk("f_wait_stall", 32'(if_stall), 32'd1);
    mem_ready = 1; mem_rdata = 32'h00500093;
    tick();
    mem_ready = 0;
    chk("f_valid", 32'(if_valid), 32'd1);
    chk("f_rdata", if_rdata, 32'h00500093);
    chk("f_stall_resp", 32'(if_stall), 32'd0);
    chk("f_mem_req_off", 32'(mem_req), 32'd0);
    if_req = 0;
    tick();
    chk("f_valid_pulse", 32'(if_valid), 32'd0);

    // ---- conflict: data first, then fetch ----
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 0; d_addr = 32'h2000;
    mem_ready = 1; mem_rdata = 32'h11111111;
    tick();
    chk("c_addr_data", mem_addr, 32'h2000);
    chk("c_starve1", 32'(dut.starve_cnt_q), 32'd1);
    tick();
    chk("c_d_valid", 32'(d_valid), 32'd1);
    chk("c_d_rdata", d_rdata, 32'h11111111);
    chk("c_no_ivalid", 32'(if_valid), 32'd0);
    d_req = 0; mem_rdata = 32'h22222222;
    tick();
    chk("c_idle_req", 32'(mem_req), 32'd0);
    tick();
    chk("c_f_req", 32'(mem_req), 32'd1);
    chk("c_f_addr", mem_addr, 32'h104);
    chk("c_starve0", 32'(dut.starve_cnt_q), 32'd0);
    tick();
    chk("c_i_valid", 32'(if_valid), 32'd1);
    chk("c_i_rdata", if_rdata, 32'h22222222);
    if_req = 0; mem_ready = 0;
    tick();

    // ---- starvation guard ----
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    mem_ready = 1; mem_rdata = 32'h33333333;
    dcnt = 0; maxst = 0; seen_fetch = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (d_valid) dcnt++;
      if (int'(dut.starve_cnt_q) > maxst) maxst = int'(dut.starve_cnt_q);
      if (!seen_fetch && mem_req && mem_addr == 32'h300) begin
        seen_fetch = 1;
        chk("s_data_grants", 32'(dcnt), 32'd4);
        chk("s_starve_clr", 32'(dut.starve_cnt_q), 32'd0);
      end
      if (if_valid) done = 1;
    end
    chk("s_fetch_done", 32'(done), 32'd1);
    chk("s_seen_fetch", 32'(seen_fetch), 32'd1);
    chk("s_starve_max", 32'(maxst), 32'd4);
    if_req = 0; d_req = 0; mem_ready = 0;
    tick();
    tick();

    // ---- store with 5 wait cycles ----
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    tick();
    chk("w_req", 32'(mem_req), 32'd1);
    chk("w_we", 32'(mem_we), 32'd1);
    chk("w_addr", mem_addr, 32'h40);
    chk("w_wdata", mem_wdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w_hold", {mem_wdata[31:3], mem_we, d_valid, d_stall},
          {29'h1BD5B7DD, 1'b1, 1'b0, 1'b1});
    end
    mem_ready = 1;
    tick();
    chk("w_valid", 32'(d_valid), 32'd1);
    chk("w_we_off", 32'(mem_we), 32'd0);
    d_req = 0; d_we = 0; mem_ready = 0;
    tick();
    chk("w_after", {30'd0, d_valid, mem_we}, 32'd0);

    // ---- flush during fetch ----
    if_req = 1; if_addr = 32'h500;
    tick();
    chk("x_req", 32'(mem_req), 32'd1);
    if_flush = 1;
    tick();
    if_flush = 0; if_addr = 32'h200;
    mem_ready = 1; mem_rdata = 32'h00000BAD;
    tick();
    mem_ready = 0;
    chk("x_no_valid", 32'(if_valid), 32'd0);
    chk("x_stall", 32'(if_stall), 32'd1);
    tick();
    chk("x_idle", 32'(mem_req), 32'd0);
    tick();
    chk("x_new_req", 32'(mem_req), 32'd1);
    chk("x_new_addr", mem_addr, 32'h200);
    mem_ready = 1; mem_rdata = 32'h00000013;
    tick();
    chk("x_new_valid", 32'(if_valid), 32'd1);
    chk("x_new_rdata", if_rdata, 32'h00000013);
    if_req = 0; mem_ready = 0;
    tick();

    // ---- reset during data access ----
    d_req = 1; d_we = 1; d_addr = 32'h60; d_wdata = 32'h12345678;
    tick();
    chk("r_busy", 32'(mem_req), 32'd1);
    rst = 1; d_req = 0; d_we = 0;
    #1;
    st = 32'(dut.state_q);
    chk("r_state", st, 32'd0);
    chk("r_outs", {28'd0, mem_req, mem_we, if_valid, d_valid}, 32'd0);
    chk("r_addr", mem_addr, 32'd0);
    chk("r_wdata", mem_wdata, 32'd0);
    tick();
    rst = 0; mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    chk("r_ign_valid", 32'(d_valid), 32'd0);
    tick();
    st = 32'(dut.state_q);
    chk("r_ign_state", st, 32'd0);
    chk("r_ign_rdata", d_rdata, 32'd0);
    mem_ready = 0;
    d_req = 1; d_we = 0; d_addr = 32'h64;
    tick();
    chk("r_next_addr", mem_addr, 32'h64);
    mem_ready = 1; mem_rdata = 32'h77;
    tick();
    chk("r_next_valid", 32'(d_valid), 32'd1);
    chk("r_next_rdata", d_rdata, 32'h77);
    d_req = 0; mem_ready = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
